// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with a fixed response latency.
// Optional alignment checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t state, state_next;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic        accept, enter_resp, do_write;
  logic        acc_we;
  logic [2:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic        is_byte, is_half, is_word, misalign, err;
  logic [ADDR_W-1:0] idx;
  logic [31:0] rword, rshift, load_val, wrep;
  logic [15:0] half_v;
  logic [3:0]  wmask;
  logic        unused_addr_bits;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the access happens on the accept edge, so it must use the live request.
  assign acc_we    = (state == S_IDLE) ? req_we    : we_q;
  assign acc_size  = (state == S_IDLE) ? req_size  : size_q;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : wdata_q;

  assign enter_resp = (state == S_WAIT && cnt == 4'd0) || (accept && LATENCY == 1);
  assign unused_addr_bits = ^acc_addr[31:ADDR_W+2];

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
      S_RESP: if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt     <= LAT_M1;
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (acc_size)
      3'b000, 3'b100: is_byte = 1'b1;
      3'b001, 3'b101: is_half = 1'b1;
      3'b010:         is_word = 1'b1;
      default:        ;
    endcase
`ifdef DMEM_MISALIGN_CHK_EN
    misalign = (is_half && acc_addr[0]) || (is_word && acc_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    err = !(is_byte || is_half || is_word) || misalign;
  end

  assign idx    = acc_addr[ADDR_W+1:2];
  assign rword  = mem[idx];
  assign rshift = rword >> {acc_addr[1:0], 3'b000};
  assign half_v = acc_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = 32'd0;
    wmask    = 4'b0000;
    wrep     = acc_wdata;
    case (acc_size)
      3'b000: load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b100: load_val = {24'd0, rshift[7:0]};
      3'b001: load_val = {{16{half_v[15]}}, half_v};
      3'b101: load_val = {16'd0, half_v};
      3'b010: load_val = rword;
      default: load_val = 32'd0;
    endcase
    if (is_byte) begin
      wmask = 4'b0001 << acc_addr[1:0];
      wrep  = {4{acc_wdata[7:0]}};
    end else if (is_half) begin
      wmask = acc_addr[1] ? 4'b1100 : 4'b0011;
      wrep  = {2{acc_wdata[15:0]}};
    end else if (is_word) begin
      wmask = 4'b1111;
    end
  end

  assign do_write = enter_resp && acc_we && !err;

  // Array has no reset; byte lanes outside the mask keep their contents.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= err;
      rsp_rdata <= (acc_we || err) ? 32'd0 : load_val;
    end
  end

endmodule
